// File: rtl/idct16_stream_pkg.sv
// idct_pkg: shared widths, the Q1.14 cosine table and the FSM state type
// for the 16-point streaming inverse DCT.
//   COS_TBL[k][n] = round(c(k) * cos((2n+1)*k*pi/32) * 2^14), n = 0..7.
//   Samples n = 8..15 come from the even/odd symmetry in the butterfly,
//   so only half of the n range is stored.
package idct_pkg;

    localparam int COEF_W   = 24;   // Q15.8 input coefficients
    localparam int SAMPLE_W = 8;    // unsigned output samples
    localparam int RAW_W    = 24;   // Q15.8 raw outputs
    localparam int COS_W    = 16;   // Q1.14 cosine constants
    localparam int PROD_W   = 40;
    localparam int SUM_W    = 44;
    localparam int NPAIR    = 8;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, EMIT} state_t;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [COS_W-1:0]  cos_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam cos_t COS_TBL [16][8] = '{
        '{ 16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096},
        '{ 16'sd5765,  16'sd5543,  16'sd5109,  16'sd4478,  16'sd3675,  16'sd2731,  16'sd1682,  16'sd568 },
        '{ 16'sd5681,  16'sd4816,  16'sd3218,  16'sd1130, -16'sd1130, -16'sd3218, -16'sd4816, -16'sd5681},
        '{ 16'sd5543,  16'sd3675,  16'sd568,  -16'sd2731, -16'sd5109, -16'sd5765, -16'sd4478, -16'sd1682},
        '{ 16'sd5352,  16'sd2217, -16'sd2217, -16'sd5352, -16'sd5352, -16'sd2217,  16'sd2217,  16'sd5352},
        '{ 16'sd5109,  16'sd568,  -16'sd4478, -16'sd5543, -16'sd1682,  16'sd3675,  16'sd5765,  16'sd2731},
        '{ 16'sd4816, -16'sd1130, -16'sd5681, -16'sd3218,  16'sd3218,  16'sd5681,  16'sd1130, -16'sd4816},
        '{ 16'sd4478, -16'sd2731, -16'sd5543,  16'sd568,   16'sd5765,  16'sd1682, -16'sd5109, -16'sd3675},
        '{ 16'sd4096, -16'sd4096, -16'sd4096,  16'sd4096,  16'sd4096, -16'sd4096, -16'sd4096,  16'sd4096},
        '{ 16'sd3675, -16'sd5109, -16'sd1682,  16'sd5765, -16'sd568,  -16'sd5543,  16'sd2731,  16'sd4478},
        '{ 16'sd3218, -16'sd5681,  16'sd1130,  16'sd4816, -16'sd4816, -16'sd1130,  16'sd5681, -16'sd3218},
        '{ 16'sd2731, -16'sd5765,  16'sd3675,  16'sd1682, -16'sd5543,  16'sd4478,  16'sd568,  -16'sd5109},
        '{ 16'sd2217, -16'sd5352,  16'sd5352, -16'sd2217, -16'sd2217,  16'sd5352, -16'sd5352,  16'sd2217},
        '{ 16'sd1682, -16'sd4478,  16'sd5765, -16'sd5109,  16'sd2731,  16'sd568,  -16'sd3675,  16'sd5543},
        '{ 16'sd1130, -16'sd3218,  16'sd4816, -16'sd5681,  16'sd5681, -16'sd4816,  16'sd3218, -16'sd1130},
        '{ 16'sd568,  -16'sd1682,  16'sd2731, -16'sd3675,  16'sd4478, -16'sd5109,  16'sd5543, -16'sd5765}
    };

    // Q.22 sum -> rounded, clamped unsigned 8-bit sample.
    function automatic logic [SAMPLE_W-1:0] sat_u8(input sum_t s);
        sum_t t;
        t = (s + 44'sd2097152) >>> 22;
        if (t < 44'sd0)
            return 8'd0;
        else if (t > 44'sd255)
            return 8'd255;
        else
            return t[SAMPLE_W-1:0];
    endfunction

    // Q.22 sum -> rounded Q15.8, clamped to the signed 24-bit range.
    function automatic logic signed [RAW_W-1:0] sat_raw(input sum_t s);
        sum_t t;
        t = (s + 44'sd8192) >>> 14;
        if (t > 44'sd8388607)
            return 24'sh7FFFFF;
        else if (t < -44'sd8388608)
            return 24'sh800000;
        else
            return t[RAW_W-1:0];
    endfunction

endpackage

// File: rtl/idct16_stream_if.sv
// idct16_stream_if: streaming handshake between a coefficient source and
// the IDCT block.
//   start            : one-cycle pulse, first coefficient pair of a block
//   COEF_A / COEF_B  : X[2k] / X[2k+1] in load cycle k (Q15.8)
//   SAMPLE_A/B, INDEX_A/B, output_en : output pair x[n], x[15-n]
//   busy             : block being loaded, computed or emitted
//   RAW_A / RAW_B    : Q15.8 raw outputs, only with IDCT_RAW_OUT_EN defined
interface idct16_stream_if;
    import idct_pkg::*;

    logic                        start;
    logic signed [COEF_W-1:0]    COEF_A;
    logic signed [COEF_W-1:0]    COEF_B;
    logic [SAMPLE_W-1:0]         SAMPLE_A;
    logic [SAMPLE_W-1:0]         SAMPLE_B;
    logic [3:0]                  INDEX_A;
    logic [3:0]                  INDEX_B;
    logic                        output_en;
    logic                        busy;
`ifdef IDCT_RAW_OUT_EN
    logic signed [RAW_W-1:0]     RAW_A;
    logic signed [RAW_W-1:0]     RAW_B;

    modport slave  (input  start, COEF_A, COEF_B,
                    output SAMPLE_A, SAMPLE_B, INDEX_A, INDEX_B, output_en, busy, RAW_A, RAW_B);
    modport master (output start, COEF_A, COEF_B,
                    input  SAMPLE_A, SAMPLE_B, INDEX_A, INDEX_B, output_en, busy, RAW_A, RAW_B);
`else
    modport slave  (input  start, COEF_A, COEF_B,
                    output SAMPLE_A, SAMPLE_B, INDEX_A, INDEX_B, output_en, busy);
    modport master (output start, COEF_A, COEF_B,
                    input  SAMPLE_A, SAMPLE_B, INDEX_A, INDEX_B, output_en, busy);
`endif

endinterface

// File: rtl/idct16_stream_butterfly.sv
// idct_butterfly: one output pair of the 16-point IDCT.
//   coef_a[i] = X[2i], coef_b[i] = X[2i+1]; cos_a/cos_b the matching
//   Q1.14 constants for the current n.
//   sum_p = E(n)+O(n) (-> x[n]), sum_m = E(n)-O(n) (-> x[15-n]),
//   both registered, Q.22 scaling.
module idct_butterfly
    import idct_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  coef_t coef_a [NPAIR],
    input  coef_t coef_b [NPAIR],
    input  cos_t  cos_a  [NPAIR],
    input  cos_t  cos_b  [NPAIR],
    output sum_t  sum_p,
    output sum_t  sum_m
);

    logic signed [PROD_W-1:0] prod_a [NPAIR];
    logic signed [PROD_W-1:0] prod_b [NPAIR];
    sum_t even_sum;
    sum_t odd_sum;

    generate
        for (genvar gi = 0; gi < NPAIR; gi++) begin : g_mul
            assign prod_a[gi] = PROD_W'(coef_a[gi]) * PROD_W'(cos_a[gi]);
            assign prod_b[gi] = PROD_W'(coef_b[gi]) * PROD_W'(cos_b[gi]);
        end
    endgenerate

    always_comb begin
        even_sum = '0;
        odd_sum  = '0;
        for (int i = 0; i < NPAIR; i++) begin
            even_sum = even_sum + SUM_W'(prod_a[i]);
            odd_sum  = odd_sum  + SUM_W'(prod_b[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_p <= '0;
            sum_m <= '0;
        end else begin
            sum_p <= even_sum + odd_sum;
            sum_m <= even_sum - odd_sum;
        end
    end

endmodule

// File: rtl/idct16_stream.sv
// idct16_stream: streaming orthonormal 16-point inverse DCT.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : idct16_stream_if.slave (start, COEF_A/B in; SAMPLE_A/B,
//           INDEX_A/B, output_en, busy out)
// Optional feature: define IDCT_RAW_OUT_EN to add RAW_A/RAW_B (Q15.8).
// Timeline for start in cycle T: load T..T+7, butterfly inputs T+8..T+15,
// output pairs T+10..T+17, busy T+1..T+17, next start accepted at T+18.
module idct16_stream
    import idct_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    idct16_stream_if.slave bus
);

    state_t     state_reg;
    logic [2:0] cnt_reg;       // load pair k during LOAD, n during CALC
    logic       calc_d1_reg;   // butterfly output holds a valid pair
    logic [2:0] n_d1_reg;

    coef_t coef_buf [16];
    coef_t coef_a_w [NPAIR];
    coef_t coef_b_w [NPAIR];
    cos_t  cos_a_w  [NPAIR];
    cos_t  cos_b_w  [NPAIR];
    sum_t  sum_p_w;
    sum_t  sum_m_w;

    logic       load_en;
    logic [2:0] load_idx;

    // The start cycle itself is load cycle 0, so IDLE also writes pair 0.
    assign load_en  = ((state_reg == IDLE) && bus.start) || (state_reg == LOAD);
    assign load_idx = (state_reg == IDLE) ? 3'd0 : cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            bus.busy  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= LOAD;
                        cnt_reg   <= 3'd1;
                        bus.busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt_reg <= cnt_reg + 3'd1;   // wraps to 0 for CALC
                    if (cnt_reg == 3'd7)
                        state_reg <= CALC;
                end
                CALC: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7)
                        state_reg <= EMIT;
                end
                EMIT: begin
                    // Two drain cycles while the last pair leaves the pipe.
                    if (cnt_reg == 3'd1) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 3'd0;
                        bus.busy  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 3'd0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient buffer: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            coef_buf[{load_idx, 1'b0}] <= bus.COEF_A;
            coef_buf[{load_idx, 1'b1}] <= bus.COEF_B;
        end
    end

    generate
        for (genvar gi = 0; gi < NPAIR; gi++) begin : g_sel
            assign coef_a_w[gi] = coef_buf[2*gi];
            assign coef_b_w[gi] = coef_buf[2*gi+1];
            assign cos_a_w[gi]  = COS_TBL[2*gi][cnt_reg];
            assign cos_b_w[gi]  = COS_TBL[2*gi+1][cnt_reg];
        end
    endgenerate

    idct_butterfly u_bfly (
        .clk    (clk),
        .reset  (reset),
        .coef_a (coef_a_w),
        .coef_b (coef_b_w),
        .cos_a  (cos_a_w),
        .cos_b  (cos_b_w),
        .sum_p  (sum_p_w),
        .sum_m  (sum_m_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            calc_d1_reg   <= 1'b0;
            n_d1_reg      <= 3'd0;
            bus.output_en <= 1'b0;
            bus.SAMPLE_A  <= '0;
            bus.SAMPLE_B  <= '0;
            bus.INDEX_A   <= 4'd0;
            bus.INDEX_B   <= 4'd0;
`ifdef IDCT_RAW_OUT_EN
            bus.RAW_A     <= '0;
            bus.RAW_B     <= '0;
`endif
        end else begin
            calc_d1_reg   <= (state_reg == CALC);
            n_d1_reg      <= cnt_reg;
            bus.output_en <= calc_d1_reg;
            if (calc_d1_reg) begin
                bus.SAMPLE_A <= sat_u8(sum_p_w);
                bus.SAMPLE_B <= sat_u8(sum_m_w);
                bus.INDEX_A  <= {1'b0, n_d1_reg};
                bus.INDEX_B  <= 4'd15 - {1'b0, n_d1_reg};
`ifdef IDCT_RAW_OUT_EN
                bus.RAW_A    <= sat_raw(sum_p_w);
                bus.RAW_B    <= sat_raw(sum_m_w);
`endif
            end
        end
    end

endmodule

// File: tb/tb_idct16_stream.sv
// tb_idct16_stream: directed self-checking bench for idct16_stream.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_idct16_stream;
    import idct_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    idct16_stream_if bus();

    idct16_stream dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int coef_q [16];
    int exp_s  [16];
    int tol_q  = 0;
    int ramp   [16] = '{1, 3, 5, 7, 9, 17, 19, 21, 22, 18, 18, 16, 8, 6, 4, 2};

    task automatic check(input string tag, input int obs, input int want, input int tol);
        checks++;
        if ((obs - want > tol) || (want - obs > tol)) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, want);
        end
    endtask

    // X[0] = q (raw Q15.8 value), all other coefficients 0; every sample = s.
    task automatic set_dc(input int q, input int s);
        for (int k = 0; k < 16; k++) begin
            coef_q[k] = (k == 0) ? q : 0;
            exp_s[k]  = s;
        end
    endtask

    // Forward orthonormal DCT of the ramp vector, quantised to Q15.8.
    task automatic set_ramp();
        real pi, acc, ck;
        pi = 3.14159265358979;
        for (int k = 0; k < 16; k++) begin
            acc = 0.0;
            for (int n = 0; n < 16; n++)
                acc = acc + ramp[n] * $cos((2.0 * n + 1.0) * k * pi / 32.0);
            ck = (k == 0) ? 0.25 : ($sqrt(2.0) / 4.0);
            coef_q[k] = $rtoi($floor(ck * acc * 256.0 + 0.5));
        end
        for (int n = 0; n < 16; n++)
            exp_s[n] = ramp[n];
    endtask

    task automatic idle_cycles(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, int'(bus.busy), 0, 0);
            check({tag, "_oen"}, int'(bus.output_en), 0, 0);
            bus.start = 1'b0;
        end
    endtask

    // One block: start in relative cycle 0, optional extra start at dup_at.
    // Relative cycle c is checked before its inputs are driven.
    task automatic run_block(input int dup_at, input string tag);
        int n;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", tag, c), int'(bus.busy), (c >= 1) ? 1 : 0, 0);
            check($sformatf("%s_oen_c%0d", tag, c), int'(bus.output_en), (c >= 10) ? 1 : 0, 0);
            if (c >= 10) begin
                n = c - 10;
                check($sformatf("%s_idxa_%0d", tag, n), int'(bus.INDEX_A), n, 0);
                check($sformatf("%s_idxb_%0d", tag, n), int'(bus.INDEX_B), 15 - n, 0);
                check($sformatf("%s_x%0d", tag, n), int'(bus.SAMPLE_A), exp_s[n], tol_q);
                check($sformatf("%s_x%0d", tag, 15 - n), int'(bus.SAMPLE_B), exp_s[15 - n], tol_q);
            end
            bus.start = (c == 0 || c == dup_at) ? 1'b1 : 1'b0;
            if (c < 8) begin
                bus.COEF_A = 24'(coef_q[2*c]);
                bus.COEF_B = 24'(coef_q[2*c+1]);
            end else begin
                bus.COEF_A = 24'h123456;
                bus.COEF_B = 24'hFEDCBA;
            end
        end
        $display("block %s checks=%0d errors=%0d", tag, checks, errors);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.COEF_A = '0;
        bus.COEF_B = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0, 0);
        check("rst_oen", int'(bus.output_en), 0, 0);
        check("rst_sa", int'(bus.SAMPLE_A), 0, 0);
        check("rst_ib", int'(bus.INDEX_B), 0, 0);
        reset = 1'b1;
        idle_cycles(3, "post_rst");

        // DC: X[0] = 16.0 -> every sample 4
        tol_q = 0;
        set_dc(16 * 256, 4);
        run_block(-1, "dc16");
        idle_cycles(2, "gap1");

        // Saturation high and low
        set_dc(2000 * 256, 255);
        run_block(-1, "sat_hi");
        set_dc(-100 * 256, 0);
        run_block(-1, "sat_lo");
        idle_cycles(2, "gap2");

        // Ramp round trip, single start and with a stray start at T+4
        tol_q = 1;
        set_ramp();
        run_block(-1, "ramp");
        run_block(4, "ramp_dup");
        idle_cycles(1, "gap3");

        // Reset pulsed at T+5 aborts the block
        tol_q = 0;
        set_dc(16 * 256, 4);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.start  = (c == 0) ? 1'b1 : 1'b0;
            bus.COEF_A = 24'(coef_q[2*c]);
            bus.COEF_B = 24'(coef_q[2*c+1]);
        end
        reset = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0, 0);
        check("arst_oen", int'(bus.output_en), 0, 0);
        check("arst_sa", int'(bus.SAMPLE_A), 0, 0);
        check("arst_sb", int'(bus.SAMPLE_B), 0, 0);
        check("arst_ia", int'(bus.INDEX_A), 0, 0);
        check("arst_ib", int'(bus.INDEX_B), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(20, "aborted");
        run_block(-1, "dc_after_rst");

        // Back-to-back: second start exactly 18 cycles after the first
        set_dc(16 * 256, 4);
        run_block(-1, "b2b_a");
        set_dc(40 * 256, 10);
        run_block(-1, "b2b_b");
        idle_cycles(3, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idct16_stream.md
IDCT16_STREAM -- requirements
Module: idct16_stream

Interface
- REQ-001 The clock and reset SHALL be: one clock; reset is asynchronous and active-low.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 reset  input  1  asynchronous, active-low reset.
- REQ-004 start  input  1  one-cycle pulse marking the first coefficient pair of a block.
- REQ-005 COEF_A  input  24  signed Q15.8, carries X[2k] in load cycle k.
- REQ-006 COEF_B  input  24  signed Q15.8, carries X[2k+1] in load cycle k.
- REQ-007 SAMPLE_A  output  8  unsigned reconstructed sample x[INDEX_A].
- REQ-008 SAMPLE_B  output  8  unsigned reconstructed sample x[INDEX_B].
- REQ-009 INDEX_A / INDEX_B  output  4 each  sample indices n and 15-n.
- REQ-010 output_en  output  1  high while SAMPLE_A/B and INDEX_A/B are valid.
- REQ-011 busy  output  1  high while a block is being loaded, computed or emitted.

Function
- REQ-012 The block SHALL compute the orthonormal 16-point inverse DCT: x[n] = sum_k c(k)·X[k]·cos((2n+1)kπ/32), with c(0)=1/4 and c(k>0)=sqrt(2)/4.
- REQ-013 The FSM states SHALL be IDLE, LOAD, CALC and EMIT, with reset entering IDLE.
- REQ-014 IDLE→LOAD SHALL occur when start=1 and busy=0; the start cycle is load cycle 0.
- REQ-015 LOAD SHALL capture COEF_A/COEF_B in load cycles k=0..7 into a 16-entry coefficient buffer, with no further start required.
- REQ-016 start asserted while busy=1 SHALL be ignored, with no effect on the buffer or outputs.
- REQ-017 CALC/EMIT SHALL produce one output pair per cycle for n=0..7:
  - x[n] = E(n)+O(n) and x[15-n] = E(n)-O(n);
  - E(n) is the sum over even k, O(n) the sum over odd k.
- REQ-018 Cosine constants SHALL be signed 16-bit Q1.14 with c(k) folded in; products are 40-bit and sums 44-bit.
- REQ-019 Output conversion SHALL add 2^21, arithmetic-shift right 22, and saturate to 0..255.
- REQ-020 Latency: if start is high in cycle T, output_en SHALL be high in cycles T+10..T+17, with INDEX_A=n and INDEX_B=15-n for n=0..7 in order.
- REQ-021 output_en SHALL be high for exactly 8 consecutive cycles per accepted block; busy SHALL be high in T+1..T+17.
- REQ-022 A start in cycle T+18 or later SHALL be accepted, giving back-to-back blocks with one idle gap minimum.

Reset
- REQ-023 While reset=0, the FSM SHALL be in IDLE and busy, output_en, SAMPLE_A/B and INDEX_A/B SHALL be 0, asynchronously.
- REQ-024 Reset asserted mid-block SHALL abort the block: no output_en for it, and the buffer contents are don't-care.

Configuration
- REQ-025 The macro IDCT_RAW_OUT_EN SHALL control raw-output ports RAW_A and RAW_B.
  - When defined: add RAW_A/RAW_B, output 24-bit signed Q15.8, valid with output_en; value = sum plus 2^13, shifted right 14, saturated to 24 bits; reset value 0.
  - When undefined: the ports and their logic are absent.

Structure
- REQ-026 Package idct_pkg SHALL hold:
  - coefficient, sample and raw widths;
  - the 16x8 Q1.14 cosine table as constants;
  - the FSM state enum.
- REQ-027 Sub-module idct_butterfly SHALL take 8 coefficients and 8 constants and return E±O registered.
- REQ-028 The top level SHALL hold the FSM, buffer, counters and output saturation.

Verification
- REQ-029 X[0]=16.0 (0x001000), all others 0 → all 16 samples =4; output_en high exactly T+10..T+17.
- REQ-030 X[0]=2000.0 → all samples 255; X[0]=-100.0 → all samples 0 (saturation).
- REQ-031 Forward DCT of x = 1,3,5,7,9,17,19,21,22,18,18,16,8,6,4,2 in Q15.8 → original samples recovered within ±1.
- REQ-032 A second start pulse at T+4 → ignored; outputs are identical to a single-start run.
- REQ-033 Reset pulsed low at T+5 → no output_en; a fresh DC block then yields all samples 4 at the correct latency.
- REQ-034 Back-to-back blocks with start at T and T+18 → 16 output_en cycles with correct, independent results.
